multicycle_ctrl: RTL and testbench

- Multi-cycle LEGv8 control unit that sequences one shared ALU/register-file/memory datapath over several cycles per instruction.
- Replaces the single-cycle main decoder on the multi-cycle core.
- Drives the datapath control lines with the same names and encodings as the single-cycle decoder, plus PC/IR sequencing and memory handshakes.

---
 rtl/multicycle_ctrl_pkg.sv | 40 ++++
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/multicycle_ctrl_op_class_decode.sv | 22 ++
 rtl/multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
package multicycle_ctrl_pkg;

    // Controller states; FETCH must stay at encoding 0 (reset/debug value).
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9,
        TRAP   = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        IC_R    = 3'd0,
        IC_LD   = 3'd1,
        IC_ST   = 3'd2,
        IC_CB   = 3'd3,
        IC_MOVZ = 3'd4,
        IC_BAD  = 3'd5
    } iclass_t;

    // Exact-match opcodes (CBZ/MOVZ wildcards live in the decoder's casez).
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and datapath.
// illegal_op exists only when ILLEGAL_OP_TRAP_EN is defined.
interface multicycle_ctrl_if;
    logic [10:0] Op;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        Reg2Loc;
    logic        ALUSrc;
    logic        MemtoReg;
    logic        RegWrite;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  ALUOp;
    logic        instr_done;
    logic        mem_timeout;
    logic [3:0]  state_o;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_op;
`endif

    // Controller side.
    modport master (
        input  Op, zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, Reg2Loc, ALUSrc, MemtoReg,
               RegWrite, MemRead, MemWrite, ALUOp, instr_done, mem_timeout, state_o
`ifdef ILLEGAL_OP_TRAP_EN
        , output illegal_op
`endif
    );

    // Datapath side.
    modport slave (
        output Op, zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, Reg2Loc, ALUSrc, MemtoReg,
               RegWrite, MemRead, MemWrite, ALUOp, instr_done, mem_timeout, state_o
`ifdef ILLEGAL_OP_TRAP_EN
        , input illegal_op
`endif
    );
endinterface

// File: rtl/multicycle_ctrl_op_class_decode.sv
// Opcode classifier: maps IR[31:21] onto an instruction class.
module multicycle_ctrl_op_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [10:0] op_i,
    output iclass_t     iclass_o
);

    // Pure combinational opcode match; wildcard bits are register/shift fields.
    always_comb begin
        iclass_o = IC_BAD;
        casez (op_i)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: iclass_o = IC_R;
            OP_LDUR:                        iclass_o = IC_LD;
            OP_STUR:                        iclass_o = IC_ST;
            11'b10110100???:                iclass_o = IC_CB;
            11'b110100101??:                iclass_o = IC_MOVZ;
            default:                        iclass_o = IC_BAD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control unit. Sequences the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB, with a bounded wait on memory handshakes.
// Optional: define ILLEGAL_OP_TRAP_EN to trap undefined opcodes in TRAP.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
    input logic                clk,
    input logic                reset,
    multicycle_ctrl_if.master  bus
);

    localparam bit               TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] Limit     = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    iclass_t          cls_dec;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             ready;
    logic             expired;

    multicycle_ctrl_op_class_decode u_dec (
        .op_i     (bus.Op),
        .iclass_o (cls_dec)
    );

    // Handshake being waited on and whether its wait budget has run out.
    always_comb begin
        ready   = (state_q == FETCH) ? bus.imem_ready : bus.dmem_ready;
        expired = TimeoutEn && !ready && (cnt_q == Limit) &&
                  (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR);
    end

    // Next state; the counter defaults to 0 so every state change clears it.
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        cnt_d     = '0;
        timeout_d = timeout_q;
        unique case (state_q)
            FETCH: begin
                if (ready)        state_d = DECODE;
                else if (expired) timeout_d = 1'b1;
                else              cnt_d = cnt_q + 1'b1;
            end
            DECODE: begin
                cls_d = cls_dec;
                unique case (cls_dec)
                    IC_R:         state_d = EXEC_R;
                    IC_LD, IC_ST: state_d = ADDR;
                    IC_CB:        state_d = BRANCH;
                    IC_MOVZ:      state_d = EXEC_I;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            EXEC_R, EXEC_I: state_d = WB_ALU;
            ADDR:           state_d = (cls_q == IC_ST) ? MEM_WR : MEM_RD;
            MEM_RD, MEM_WR: begin
                if (ready) begin
                    state_d = (state_q == MEM_RD) ? WB_MEM : FETCH;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = FETCH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB_ALU, WB_MEM, BRANCH: state_d = FETCH;
            TRAP:                   state_d = TRAP;
            default:                state_d = FETCH;
        endcase
    end

    // Controller state with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            cls_q     <= IC_BAD;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Moore decode plus ready/zero-qualified strobes; everything low in reset.
    always_comb begin
        bus.imem_req    = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.Reg2Loc     = 1'b0;
        bus.ALUSrc      = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.ALUOp       = ALU_ADD;
        bus.instr_done  = 1'b0;
        bus.mem_timeout = timeout_q & ~reset;
        bus.state_o     = reset ? 4'd0 : state_q;
`ifdef ILLEGAL_OP_TRAP_EN
        bus.illegal_op  = !reset && (state_q == TRAP);
`endif
        if (!reset) begin
            unique case (state_q)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_write = bus.imem_ready;
                    bus.pc_write = bus.imem_ready;
                end
`ifdef ILLEGAL_OP_TRAP_EN
                DECODE: ;
`else
                DECODE: bus.instr_done = (cls_dec == IC_BAD);
`endif
                EXEC_R: bus.ALUOp = ALU_FUNCT;
                EXEC_I: begin
                    bus.ALUSrc = 1'b1;
                    bus.ALUOp  = ALU_PASS;
                end
                ADDR: begin
                    bus.Reg2Loc = (cls_q == IC_ST);
                    bus.ALUSrc  = 1'b1;
                end
                MEM_RD: bus.MemRead = 1'b1;
                MEM_WR: begin
                    bus.Reg2Loc    = 1'b1;
                    bus.MemWrite   = 1'b1;
                    bus.instr_done = bus.dmem_ready;
                end
                WB_ALU: begin
                    bus.RegWrite   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                WB_MEM: begin
                    bus.RegWrite   = 1'b1;
                    bus.MemtoReg   = 1'b1;
                    bus.instr_done = 1'b1;
                end
                BRANCH: begin
                    bus.Reg2Loc    = 1'b1;
                    bus.ALUOp      = ALU_PASS;
                    bus.pc_write   = bus.zero;
                    bus.pc_src     = bus.zero;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a per-instruction model expands each
// instruction into its expected per-cycle control trace, replayed against the DUT.
module tb_multicycle_ctrl;

    localparam int unsigned T = 4;

    // Expected-vector bit masks: {req,irw,pcw,pcs,r2l,asrc,m2r,rw,mr,mw,aluop[1:0],done}
    localparam logic [12:0] M_REQ  = 13'h1000;
    localparam logic [12:0] M_IRW  = 13'h0800;
    localparam logic [12:0] M_PCW  = 13'h0400;
    localparam logic [12:0] M_PCS  = 13'h0200;
    localparam logic [12:0] M_R2L  = 13'h0100;
    localparam logic [12:0] M_ASRC = 13'h0080;
    localparam logic [12:0] M_M2R  = 13'h0040;
    localparam logic [12:0] M_RW   = 13'h0020;
    localparam logic [12:0] M_MR   = 13'h0010;
    localparam logic [12:0] M_MW   = 13'h0008;
    localparam logic [12:0] M_PASS = 13'h0002;
    localparam logic [12:0] M_FUNC = 13'h0004;
    localparam logic [12:0] M_DONE = 13'h0001;

    typedef struct packed {
        logic        rst;
        logic [10:0] op;
        logic        ir;
        logic        dr;
        logic        z;
        logic [12:0] exp;
        logic        to;
        logic        ill;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   ncyc = 0;
    bit   to_flag = 1'b0;
    cyc_t q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // 0 R, 1 LDUR, 2 STUR, 3 CBZ, 4 MOVZ, 5 undefined
    function automatic int cls(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return 0;
        if (op == 11'b11111000010) return 1;
        if (op == 11'b11111000000) return 2;
        if (op[10:3] == 8'b10110100) return 3;
        if (op[10:2] == 9'b110100101) return 4;
        return 5;
    endfunction

    function automatic void push(input logic [10:0] op, input bit ir, input bit dr,
                                 input bit z, input logic [12:0] e, input bit ill);
        cyc_t c;
        c.rst = 1'b0; c.op = op; c.ir = ir; c.dr = dr; c.z = z;
        c.exp = e; c.to = to_flag; c.ill = ill;
        q.push_back(c);
    endfunction

    function automatic void push_reset();
        cyc_t c;
        to_flag = 1'b0;
        c.rst = 1'b1; c.op = 11'($urandom); c.ir = rb(); c.dr = rb(); c.z = rb();
        c.exp = '0; c.to = 1'b0; c.ill = 1'b0;
        q.push_back(c);
    endfunction

    // Fetch with imem_ready low for w cycles in total; restarts after each timeout.
    function automatic void m_fetch(input int w);
        int i = 0;
        int rem = w;
        while (1) begin
            if (i == rem) begin
                push(11'($urandom), 1'b1, rb(), rb(), M_REQ | M_IRW | M_PCW, 1'b0);
                return;
            end
            push(11'($urandom), 1'b0, rb(), rb(), M_REQ, 1'b0);
            if (i == int'(T)) begin
                to_flag = 1'b1;
                rem = rem - int'(T) - 1;
                i = 0;
            end else begin
                i++;
            end
        end
    endfunction

    // Data access with dmem_ready low for w cycles; returns 0 on timeout.
    function automatic bit m_mem(input logic [10:0] op, input bit st, input int w);
        logic [12:0] e = st ? (M_R2L | M_MW) : M_MR;
        for (int i = 0; ; i++) begin
            if (i == w) begin
                push(op, rb(), 1'b1, rb(), st ? (e | M_DONE) : e, 1'b0);
                return 1'b1;
            end
            push(op, rb(), 1'b0, rb(), e, 1'b0);
            if (i == int'(T)) begin
                to_flag = 1'b1;
                return 1'b0;
            end
        end
    endfunction

    function automatic void m_instr(input logic [10:0] op, input int wi, input int wd,
                                    input bit z);
        int c = cls(op);
        bit ok;
        m_fetch(wi);
        case (c)
            0: begin
                push(op, rb(), rb(), rb(), '0, 1'b0);
                push(op, rb(), rb(), rb(), M_FUNC, 1'b0);
                push(op, rb(), rb(), rb(), M_RW | M_DONE, 1'b0);
            end
            4: begin
                push(op, rb(), rb(), rb(), '0, 1'b0);
                push(op, rb(), rb(), rb(), M_ASRC | M_PASS, 1'b0);
                push(op, rb(), rb(), rb(), M_RW | M_DONE, 1'b0);
            end
            1, 2: begin
                push(op, rb(), rb(), rb(), '0, 1'b0);
                push(op, rb(), rb(), rb(), (c == 2) ? (M_R2L | M_ASRC) : M_ASRC, 1'b0);
                ok = m_mem(op, c == 2, wd);
                if (ok && c == 1) push(op, rb(), rb(), rb(), M_RW | M_M2R | M_DONE, 1'b0);
            end
            3: begin
                push(op, rb(), rb(), z, '0, 1'b0);
                push(op, rb(), rb(), z,
                     M_R2L | M_PASS | M_DONE | (z ? (M_PCW | M_PCS) : 13'h0), 1'b0);
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                push(op, rb(), rb(), rb(), '0, 1'b0);
                for (int k = 0; k < 4; k++) push(op, rb(), rb(), rb(), '0, 1'b1);
                push_reset();
`else
                push(op, rb(), rb(), rb(), M_DONE, 1'b0);
`endif
            end
        endcase
    endfunction

    function automatic logic [10:0] rnd_instr();
        logic [10:0] op;
        do begin
            case ($urandom_range(0, 8))
                0: op = 11'b10001011000;
                1: op = 11'b11001011000;
                2: op = 11'b10001010000;
                3: op = 11'b10101010000;
                4: op = 11'b11111000010;
                5: op = 11'b11111000000;
                6: op = {8'b10110100, 3'($urandom)};
                7: op = {9'b110100101, 2'($urandom)};
                default: op = 11'($urandom);
            endcase
`ifdef ILLEGAL_OP_TRAP_EN
        end while (cls(op) == 5);
`else
        end while (1'b0);
`endif
        return op;
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, ncyc, got, exp);
        end
    endtask

    // Drive each planned cycle after the edge, sample on the falling edge.
    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            reset = c.rst;
            bus.Op = c.op;
            bus.imem_ready = c.ir;
            bus.dmem_ready = c.dr;
            bus.zero = c.z;
            @(negedge clk);
            chk("ctrl", {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.Reg2Loc,
                         bus.ALUSrc, bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite,
                         bus.ALUOp, bus.instr_done}, c.exp);
            chk("mem_timeout", {12'h0, bus.mem_timeout}, {12'h0, c.to});
            if (c.rst) chk("state_rst", {9'h0, bus.state_o}, 13'h0);
`ifdef ILLEGAL_OP_TRAP_EN
            chk("illegal_op", {12'h0, bus.illegal_op}, {12'h0, c.ill});
`endif
            ncyc++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.Op = '0;
        bus.imem_ready = 1'b1;
        bus.dmem_ready = 1'b0;
        bus.zero = 1'b0;
        for (int k = 0; k < 3; k++) push_reset();
        // Directed: zero-wait ADD, slow LDUR, both CBZ outcomes.
        m_instr(11'b10001011000, 0, 0, 1'b0);
        m_instr(11'b11111000010, 0, 3, 1'b0);
        m_instr(11'b10110100101, 0, 0, 1'b1);
        m_instr(11'b10110100101, 0, 0, 1'b0);
        // STUR never answered: timeout, then sticky flag.
        m_instr(11'b11111000000, 0, 1000, 1'b0);
        m_instr(11'b00000000000, 0, 0, 1'b0);
        // Ready arriving exactly at the limit wins; one past it times out.
        m_instr(11'b11111000010, 0, 4, 1'b0);
        m_instr(11'b11111000000, 4, 4, 1'b0);
        m_instr(11'b10101010000, 5, 0, 1'b0);
        m_instr(11'b11010010111, 0, 0, 1'b0);
        run_q();
        // Randomized instruction stream with random wait states.
        for (int n = 0; n < 80; n++) begin
            m_instr(rnd_instr(), $urandom_range(0, 6), $urandom_range(0, 6), rb());
        end
        run_q();
        // Reset while MemRead is pending: no strobes, restart from FETCH.
        m_fetch(0);
        push(11'b11111000010, rb(), rb(), rb(), '0, 1'b0);
        push(11'b11111000010, rb(), rb(), rb(), M_ASRC, 1'b0);
        push(11'b11111000010, rb(), 1'b0, rb(), M_MR, 1'b0);
        push_reset();
        m_instr(11'b10001011000, 0, 0, 1'b0);
        run_q();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
